// File: rtl/demux_1ton_buffered.sv
// 1-to-N_OUT flit demux with a one-entry output register per channel and a saturating drop counter.
// Define DEMUX_BCAST_EN to add the in_bcast port and broadcast-to-all-outputs support.
`ifndef IN_ROUTER_SIZE
`define IN_ROUTER_SIZE 8
`endif

module demux_1ton_buffered #(
  parameter int DATA_W = `IN_ROUTER_SIZE,
  parameter int N_OUT  = 2,  // legal 2..16, with 2**SEL_W >= N_OUT
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                    in_bcast,
`endif
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [7:0]              drop_cnt
);

  logic [N_OUT-1:0]        out_valid_q, out_valid_d;
  logic [N_OUT*DATA_W-1:0] out_data_q,  out_data_d;
  logic [7:0]              drop_cnt_q,  drop_cnt_d;

  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] sel_hit;
  logic [N_OUT-1:0] wr_en;
  logic             sel_oob;
  logic             bcast;
  logic             accept;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    free    = ~out_valid_q | out_ready;
    sel_hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
    sel_oob = (32'(in_sel) >= 32'(N_OUT));

`ifdef DEMUX_BCAST_EN
    bcast = in_valid & in_bcast;
`else
    bcast = 1'b0;
`endif

    // Out-of-range selects are always consumed so a bad route can never wedge the input.
    if (bcast) in_ready = &free;
    else       in_ready = sel_oob | (|(sel_hit & free));

    accept = in_valid & in_ready;
    wr_en  = '0;
    if (accept) wr_en = bcast ? '1 : sel_hit;

    // A write in the same cycle as a drain keeps the slot full: one flit per cycle, no bubble.
    out_valid_d = (out_valid_q & ~out_ready) | wr_en;
    out_data_d  = out_data_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (wr_en[k]) out_data_d[k*DATA_W +: DATA_W] = in_data;
    end

    drop_cnt_d = drop_cnt_q;
    if (accept && sel_oob && !bcast && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= '0;
      // NOTE: the data registers are reset as well because out_data is defined as zero out of reset.
      out_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_1ton_buffered.sv
// Bench for demux_1ton_buffered (DATA_W=8, N_OUT=3, SEL_W=2): per-output scoreboard plus directed scenarios.
// Broadcast scenario is compiled in when DEMUX_BCAST_EN is defined.
module tb_demux_1ton_buffered;
  localparam int DATA_W = 8;
  localparam int N_OUT  = 3;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
`ifdef DEMUX_BCAST_EN
  logic                    in_bcast;
`endif
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [7:0]              drop_cnt;

  demux_1ton_buffered #(.DATA_W(DATA_W), .N_OUT(N_OUT), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: expected out_valid, drop count and per-output data queues.
  logic [N_OUT-1:0] mv;
  int               md;
  logic [7:0]       sb_q [N_OUT][$];

  always @(negedge clk) begin
    logic [N_OUT-1:0] m_free;
    logic [N_OUT-1:0] wr;
    logic             exp_ready;
    logic             bc;
    logic [7:0]       got;
    if (reset) begin
      mv = '0;
      md = 0;
      for (int k = 0; k < N_OUT; k++) sb_q[k].delete();
    end else begin
      m_free = ~mv | out_ready;
`ifdef DEMUX_BCAST_EN
      bc = in_valid & in_bcast;
`else
      bc = 1'b0;
`endif
      if (bc)                exp_ready = &m_free;
      else if (in_sel >= 2'd3) exp_ready = 1'b1;
      else                   exp_ready = m_free[in_sel];
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(mv));
      check("drop_cnt", 32'(drop_cnt), 32'(md));
      for (int k = 0; k < N_OUT; k++) begin
        if (mv[k] && out_ready[k]) begin
          check("sb_nonempty", 32'(sb_q[k].size() > 0), 32'd1);
          if (sb_q[k].size() > 0) begin
            got = sb_q[k].pop_front();
            check($sformatf("out_data%0d", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(got));
          end
        end
      end
      wr = '0;
      if (in_valid && exp_ready) begin
        if (bc)                wr = '1;
        else if (in_sel < 2'd3) wr[in_sel] = 1'b1;
        else if (md < 255)     md++;
      end
      for (int k = 0; k < N_OUT; k++) if (wr[k]) sb_q[k].push_back(in_data);
      mv = (mv & ~out_ready) | wr;
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
`ifdef DEMUX_BCAST_EN
    in_bcast  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state and idle readiness for every select value
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check($sformatf("idle_ready_sel%0d", s), 32'(in_ready), 32'd1);
    end
    in_sel = '0;
    cyc();

    // 2: single flit to output 1, then drain
    out_ready = 3'b111; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA5;
    cyc();
    in_valid = 1'b0;
    check("s2_valid", 32'(out_valid), 32'b010);
    check("s2_data1", 32'(out_data[15:8]), 32'hA5);
    cyc();
    check("s2_drained", 32'(out_valid), 32'd0);
    check("s2_data_kept", 32'(out_data[15:8]), 32'hA5);

    // 3: stall on output 0, other outputs still flow, release
    out_ready = 3'b110; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
    cyc();
    in_data = 8'h22;
    #1;
    check("s3_refused", 32'(in_ready), 32'd0);
    cyc();
    check("s3_held_data", 32'(out_data[7:0]), 32'h11);
    check("s3_held_valid", 32'(out_valid), 32'b001);
    in_sel = 2'd2; in_data = 8'h33;
    #1;
    check("s3_other_ready", 32'(in_ready), 32'd1);
    cyc();
    check("s3_data2", 32'(out_data[23:16]), 32'h33);
    check("s3_still_held", 32'(out_data[7:0]), 32'h11);
    check("s3_valid_101", 32'(out_valid), 32'b101);
    in_sel = 2'd0; in_data = 8'h22; out_ready = 3'b111;
    #1;
    check("s3_release_ready", 32'(in_ready), 32'd1);
    cyc();
    check("s3_data0_new", 32'(out_data[7:0]), 32'h22);
    check("s3_valid_001", 32'(out_valid), 32'b001);
    in_valid = 1'b0;
    cyc();

    // 4: back-to-back stream to output 2, no bubble
    in_valid = 1'b1; in_sel = 2'd2;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      #1;
      check("s4_ready", 32'(in_ready), 32'd1);
      cyc();
      check("s4_data2", 32'(out_data[23:16]), 32'(i));
      check("s4_valid", 32'(out_valid), 32'b100);
    end
    in_valid = 1'b0;
    cyc();

    // 5: out-of-range selects are consumed and counted, saturating at 255
    in_valid = 1'b1; in_sel = 2'd3;
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    check("s5_drop_sat", 32'(drop_cnt), 32'd255);
    check("s5_no_valid", 32'(out_valid), 32'd0);
    cyc();

`ifdef DEMUX_BCAST_EN
    // 6: broadcast waits for every slot, then loads all outputs
    out_ready = 3'b101; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h77;
    cyc();
    in_bcast = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
    #1;
    check("s6_bcast_refused", 32'(in_ready), 32'd0);
    cyc();
    check("s6_stalled_valid", 32'(out_valid), 32'b010);
    check("s6_stalled_data", 32'(out_data[15:8]), 32'h77);
    out_ready = 3'b111;
    #1;
    check("s6_bcast_ready", 32'(in_ready), 32'd1);
    cyc();
    in_bcast = 1'b0; in_valid = 1'b0;
    check("s6_all_valid", 32'(out_valid), 32'b111);
    check("s6_all_data", 32'(out_data), 32'h5A5A5A);
    check("s6_drop_same", 32'(drop_cnt), 32'd255);
`endif

    // drain everything and confirm the scoreboard emptied
    out_ready = 3'b111; in_valid = 1'b0;
    cyc();
    cyc();
    check("sb_drained", 32'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size()), 32'd0);

    // mid-operation reset discards held flits and a simultaneous accept
    out_ready = 3'b000; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h99;
    cyc();
    check("rst2_pre_valid", 32'(out_valid), 32'b001);
    reset = 1'b1; in_sel = 2'd1; in_data = 8'h44;
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_data", 32'(out_data), 32'd0);
    check("rst2_drop", 32'(drop_cnt), 32'd0);
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
